// File: rtl/axi4bus_pkg.sv
// Shared AXI4 forward-bus definitions: AR forward word layout and skid-buffer states.
// The field offsets are shared with the bus-side separator.
package axi4bus_pkg;

  localparam int unsigned AR_FWD_W = 77;

  localparam int unsigned ARID_W     = 8;
  localparam int unsigned ARADDR_W   = 36;
  localparam int unsigned ARLEN_W    = 8;
  localparam int unsigned ARSIZE_W   = 3;
  localparam int unsigned ARBURST_W  = 2;
  localparam int unsigned ARLOCK_W   = 1;
  localparam int unsigned ARCACHE_W  = 4;
  localparam int unsigned ARPROT_W   = 3;
  localparam int unsigned ARQOS_W    = 4;
  localparam int unsigned ARREGION_W = 4;
  localparam int unsigned ARUSER_W   = 4;

  localparam int unsigned ARUSER_LSB   = 0;
  localparam int unsigned ARREGION_LSB = 4;
  localparam int unsigned ARQOS_LSB    = 8;
  localparam int unsigned ARPROT_LSB   = 12;
  localparam int unsigned ARCACHE_LSB  = 15;
  localparam int unsigned ARLOCK_LSB   = 19;
  localparam int unsigned ARBURST_LSB  = 20;
  localparam int unsigned ARSIZE_LSB   = 22;
  localparam int unsigned ARLEN_LSB    = 25;
  localparam int unsigned ARADDR_LSB   = 33;
  localparam int unsigned ARID_LSB     = 69;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/fwd_skid_buffer.sv
// Two-entry skid buffer: full throughput with all valid/ready paths registered.
// Reusable for any forward path width.
module fwd_skid_buffer
  import axi4bus_pkg::*;
#(
  parameter int unsigned W = AR_FWD_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  skid_state_e r_state;
  skid_state_e w_next_state;
  logic [W-1:0] r_main;
  logic [W-1:0] r_skid;
  logic         r_ready;

  logic w_accept;
  logic w_send;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  assign w_accept = i_valid & r_ready;
  assign w_send   = (r_state != EMPTY) & i_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next_state = BUSY;
          w_load_main  = 1'b1;
        end
      end
      BUSY: begin
        if (w_accept && w_send) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_next_state = FULL;
          w_load_skid  = 1'b1;
        end else if (w_send) begin
          w_next_state = EMPTY;
        end
      end
      FULL: begin
        if (w_send) begin
          w_next_state     = BUSY;
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  // Ready is registered from the next state so it never depends on i_ready combinationally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state != FULL);
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : i_data;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

  assign o_ready = r_ready;
  assign o_data  = r_main;
  assign o_valid = (r_state != EMPTY);

endmodule

// File: rtl/r_forward_combiner.sv
// AR forward-path transmitter: packs the AXI4 AR channel into the 77-bit
// forward word and registers it through a two-entry skid buffer.
module r_forward_combiner
  import axi4bus_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [ARID_W-1:0]     ARID,
  input  logic [ARADDR_W-1:0]   ARADDR,
  input  logic [ARLEN_W-1:0]    ARLEN,
  input  logic [ARSIZE_W-1:0]   ARSIZE,
  input  logic [ARBURST_W-1:0]  ARBURST,
  input  logic [ARLOCK_W-1:0]   ARLOCK,
  input  logic [ARCACHE_W-1:0]  ARCACHE,
  input  logic [ARPROT_W-1:0]   ARPROT,
  input  logic [ARQOS_W-1:0]    ARQOS,
  input  logic [ARREGION_W-1:0] ARREGION,
  input  logic [ARUSER_W-1:0]   ARUSER,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [AR_FWD_W-1:0]   DATA,
  output logic                  VALID,
  input  logic                  READY
);

  logic [AR_FWD_W-1:0] w_ar_word;

  always_comb begin
    w_ar_word = '0;
    w_ar_word[ARID_LSB     +: ARID_W]     = ARID;
    w_ar_word[ARADDR_LSB   +: ARADDR_W]   = ARADDR;
    w_ar_word[ARLEN_LSB    +: ARLEN_W]    = ARLEN;
    w_ar_word[ARSIZE_LSB   +: ARSIZE_W]   = ARSIZE;
    w_ar_word[ARBURST_LSB  +: ARBURST_W]  = ARBURST;
    w_ar_word[ARLOCK_LSB   +: ARLOCK_W]   = ARLOCK;
    w_ar_word[ARCACHE_LSB  +: ARCACHE_W]  = ARCACHE;
    w_ar_word[ARPROT_LSB   +: ARPROT_W]   = ARPROT;
    w_ar_word[ARQOS_LSB    +: ARQOS_W]    = ARQOS;
    w_ar_word[ARREGION_LSB +: ARREGION_W] = ARREGION;
    w_ar_word[ARUSER_LSB   +: ARUSER_W]   = ARUSER;
  end

  fwd_skid_buffer #(
    .W (AR_FWD_W)
  ) u_skid (
    .i_clk   (CLK),
    .i_rst_n (RESETn),
    .i_data  (w_ar_word),
    .i_valid (ARVALID),
    .o_ready (ARREADY),
    .o_data  (DATA),
    .o_valid (VALID),
    .i_ready (READY)
  );

endmodule

// File: doc/r_forward_combiner.md
# r_forward_combiner

Packs the AXI4 read-address (AR) channel of a manager-side port into the 77-bit forward-bus word and registers it through a two-entry skid buffer. It is the transmit end of the AR forward path: the bus-side separator consumes its DATA/VALID/READY. The skid buffer sustains full throughput of one beat per cycle and breaks every combinational path between ARVALID/ARREADY and VALID/READY.

## Interface
Parameters:
- none; all widths are fixed by the 77-bit AR forward word (package constants).

Ports:
- CLK  in  1  single clock; all state on rising edge
- RESETn  in  1  synchronous, active-low reset
- ARID  in  8  read ID
- ARADDR  in  36  read address
- ARLEN  in  8  burst length − 1
- ARSIZE  in  3  beat size
- ARBURST  in  2  burst type
- ARLOCK  in  1  lock
- ARCACHE  in  4  cache attributes
- ARPROT  in  3  protection
- ARQOS  in  4  QoS
- ARREGION  in  4  region
- ARUSER  in  4  user
- ARVALID  in  1  AR beat valid
- ARREADY  out  1  AR beat accepted (registered)
- DATA  out  77  packed forward word (registered)
- VALID  out  1  DATA valid (registered)
- READY  in  1  downstream accepts DATA

## Operation
- Packing, MSB→LSB: ARID[76:69], ARADDR[68:33], ARLEN[32:25], ARSIZE[24:22], ARBURST[21:20], ARLOCK[19], ARCACHE[18:15], ARPROT[14:12], ARQOS[11:8], ARREGION[7:4], ARUSER[3:0]. No field is altered or checked.
- Storage: main register (drives DATA) and skid register.
- States:
  - EMPTY: main invalid.
  - BUSY: main valid, skid empty.
  - FULL: both valid.
- Accept = ARVALID & ARREADY; send = VALID & READY.
- Transitions:
  - EMPTY: accept → BUSY (main ← packed input).
  - BUSY: accept & send → BUSY (main ← input); accept & !send → FULL (skid ← input); !accept & send → EMPTY; otherwise hold.
  - FULL: send → BUSY (main ← skid); otherwise hold. No accept is possible (ARREADY = 0).
- VALID = (state ≠ EMPTY).
- ARREADY register next value = (next_state ≠ FULL).
- Ordering is strict FIFO; no beat is dropped or duplicated.
- DATA is held stable while VALID & !READY.

## Timing
- Reset (RESETn low at a clock edge): state EMPTY, VALID 0, DATA 0, ARREADY 0, skid cleared.
- First edge with RESETn high: ARREADY becomes 1.
- Reset mid-operation discards both entries. The downstream must ignore a VALID that drops in this case.
- Latency: a beat accepted at edge N appears on DATA/VALID after edge N; earliest send is at edge N+1.
- Throughput: 1 beat/cycle with READY held high.
- Backpressure: READY low with continuous ARVALID gives 2 accepts, then ARREADY = 0 from the following cycle.
- Release from FULL: ARREADY returns to 1 one cycle after the first send.
- Simultaneous accept and send in BUSY is legal and leaves the state at BUSY.
- ARREADY does not depend combinationally on READY. VALID/DATA do not depend combinationally on any AR input.

## Structure
- Shared package (axi4bus_pkg) holds:
  - AR_FWD_W = 77;
  - per-field width and LSB-offset constants for the layout above (shared with the separator);
  - skid state enum {EMPTY, BUSY, FULL}.
- Sub-module fwd_skid_buffer: parameterised width, two-entry skid with in/out valid-ready. It is reusable for the AW and W forward paths.
- The top level performs only the concatenation and instantiates the sub-module.

## Test plan
- Reset/single beat: hold RESETn low for 3 cycles and check ARREADY = 0, VALID = 0, DATA = 0. Release, then present ARID = 8'h5A, ARADDR = 36'h9_8765_4321, ARLEN = 8'h0F, other fields 0. Expect VALID = 1 one cycle later with DATA[76:69] = 8'h5A, DATA[68:33] = 36'h987654321, DATA[32:25] = 8'h0F.
- Field walk: drive a walking-1 across each AR field in turn. The single DATA bit at the documented offset must be set, and all others 0.
- Streaming: 16 beats with incrementing ARID and READY = 1 throughout. Expect 16 sends on consecutive cycles, in order, with ARREADY never low.
- Backpressure: READY = 0 with ARVALID continuous. Expect exactly 2 accepts, ARREADY = 0 from the third cycle, and DATA stable. Raising READY gives the 2 beats in order, then ARREADY = 1 one cycle after the first send.
- Random stall: random ARVALID/READY, 1000 beats. The scoreboard must show no loss, duplication or reordering. Check handshake stability assertions: DATA stable while VALID & !READY, and VALID not deasserted without a send except on reset.
- Mid-operation reset: in FULL, pull RESETn low for 1 cycle. Expect VALID = 0 and ARREADY = 0 on the next cycle, ARREADY = 1 one cycle after release, and no stale beat emitted.
